// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: register indices and hazard-control FSM states.
package cpu_types_pkg;
   typedef logic [4:0] regbits_t;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DWAIT = 2'd1,
      RWAIT = 2'd2,
      HALT  = 2'd3
   } hazstate_t;

   localparam regbits_t REG_ZERO = 5'd0;
endpackage

// File: rtl/hazard_ctrl.sv
// Pipeline latch enable/flush and PC-load control for the 5-stage core.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
   import cpu_types_pkg::*;
`ifdef HAZARD_PERF_EN
#(
   parameter int CNTW = 32
)
`endif
(
   input  logic     CLK,
   input  logic     RST,
   input  logic     ihit,
   input  logic     dhit,
   input  logic     exmem_dren,
   input  logic     exmem_dwen,
   input  logic     idex_dren,
   input  regbits_t idex_rt,
   input  regbits_t ifid_rs,
   input  regbits_t ifid_rt,
   input  logic     redirect,
   input  logic     memwb_halt,
   output logic     pc_en,
   output logic     ifid_en,
   output logic     idex_en,
   output logic     exmem_en,
   output logic     memwb_en,
   output logic     ifid_flush,
   output logic     idex_flush,
   output logic     exmem_flush,
   output logic     memwb_flush,
   output logic     halted
`ifdef HAZARD_PERF_EN
   ,
   output logic [CNTW-1:0] cyc_cnt,
   output logic [CNTW-1:0] stall_cnt,
   output logic [CNTW-1:0] flush_cnt
`endif
);

   hazstate_t state, nxt_state;
   logic      dstall, lu, redir_taken;

   assign dstall = (exmem_dren | exmem_dwen) & ~dhit;
   assign lu     = idex_dren & (idex_rt != REG_ZERO) &
                   ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

   always_ff @(posedge CLK) begin
      if (RST) state <= RUN;
      else     state <= nxt_state;
   end

   always_comb begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      memwb_flush = 1'b0;
      halted      = 1'b0;
      redir_taken = 1'b0;
      nxt_state   = RUN;
      if (RST) begin
         // Latches are cleared together with the core reset.
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
         memwb_flush = 1'b1;
      end else if (state == HALT || memwb_halt) begin
         halted    = 1'b1;
         nxt_state = HALT;
      end else if (dstall) begin
         nxt_state = DWAIT;
      end else if (redirect && !ihit) begin
         // Bubble WB so the branch is not retired twice while the target fetch misses.
         memwb_flush = 1'b1;
         nxt_state   = RWAIT;
      end else if (redirect) begin
         pc_en       = 1'b1;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
         memwb_en    = 1'b1;
         redir_taken = 1'b1;
      end else if (lu && ihit) begin
         idex_flush = 1'b1;
         exmem_en   = 1'b1;
         memwb_en   = 1'b1;
      end else if (ihit) begin
         pc_en    = 1'b1;
         ifid_en  = 1'b1;
         idex_en  = 1'b1;
         exmem_en = 1'b1;
         memwb_en = 1'b1;
      end else begin
         ifid_flush = 1'b1;
         idex_en    = 1'b1;
         exmem_en   = 1'b1;
         memwb_en   = 1'b1;
      end
   end

`ifdef HAZARD_PERF_EN
   function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge CLK) begin
      if (RST) begin
         cyc_cnt   <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (state != HALT) begin
         cyc_cnt <= sat_inc(cyc_cnt);
         if (!pc_en)      stall_cnt <= sat_inc(stall_cnt);
         if (redir_taken) flush_cnt <= sat_inc(flush_cnt);
      end
   end
`else
   logic unused_redir;
   assign unused_redir = redir_taken;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and random checks of hazard_ctrl against a rule-table reference model.
module tb_hazard_ctrl;
   import cpu_types_pkg::*;

   logic     CLK = 1'b0;
   logic     RST, ihit, dhit, exmem_dren, exmem_dwen, idex_dren, redirect, memwb_halt;
   regbits_t idex_rt, ifid_rs, ifid_rt;
   logic     pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic     ifid_flush, idex_flush, exmem_flush, memwb_flush, halted;
`ifdef HAZARD_PERF_EN
   logic [31:0] cyc_cnt, stall_cnt, flush_cnt;
   int unsigned cyc_m, stall_m, flush_m;
`endif

   int checks = 0;
   int errors = 0;
   bit halt_m = 1'b0;

   hazard_ctrl dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
      .exmem_dren(exmem_dren), .exmem_dwen(exmem_dwen),
      .idex_dren(idex_dren), .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
      .redirect(redirect), .memwb_halt(memwb_halt),
      .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
      .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .halted(halted)
`ifdef HAZARD_PERF_EN
      , .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   always #5 CLK = ~CLK;

   // Output vector order: pc,ifid,idex,exmem,memwb enables | ifid,idex,exmem,memwb flushes | halted
   function automatic void model(output logic [9:0] e, output bit r4);
      bit ds, l;
      ds = (exmem_dren || exmem_dwen) && !dhit;
      l  = idex_dren && (idex_rt != 0) && (idex_rt == ifid_rs || idex_rt == ifid_rt);
      r4 = 1'b0;
      if (RST)                          e = 10'b00000_1111_0;
      else if (halt_m || memwb_halt)    e = 10'b00000_0000_1;
      else if (ds)                      e = 10'b00000_0000_0;
      else if (redirect && !ihit)       e = 10'b00000_0001_0;
      else if (redirect) begin          e = 10'b10001_1110_0; r4 = 1'b1; end
      else if (l && ihit)               e = 10'b00011_0100_0;
      else if (ihit)                    e = 10'b11111_0000_0;
      else                              e = 10'b00111_1000_0;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input string tag);
      logic [9:0] e;
      bit r4;
      @(negedge CLK);
      model(e, r4);
      check(tag, {22'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                  ifid_flush, idex_flush, exmem_flush, memwb_flush, halted}, {22'd0, e});
`ifdef HAZARD_PERF_EN
      check({tag, "_cyc"}, cyc_cnt, cyc_m);
      check({tag, "_stall"}, stall_cnt, stall_m);
      check({tag, "_flush"}, flush_cnt, flush_m);
`endif
      @(posedge CLK);
      if (RST) begin
         halt_m = 1'b0;
`ifdef HAZARD_PERF_EN
         cyc_m = 0; stall_m = 0; flush_m = 0;
`endif
      end else begin
`ifdef HAZARD_PERF_EN
         if (!halt_m) begin
            cyc_m++;
            if (!e[9]) stall_m++;
            if (r4)    flush_m++;
         end
`endif
         if (memwb_halt) halt_m = 1'b1;
      end
      #1;
   endtask

   task automatic idle();
      RST = 0; ihit = 0; dhit = 0; exmem_dren = 0; exmem_dwen = 0; idex_dren = 0;
      redirect = 0; memwb_halt = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
   endtask

   initial begin
`ifdef HAZARD_PERF_EN
      cyc_m = 0; stall_m = 0; flush_m = 0;
`endif
      idle();
      RST = 1;
      step("reset0");
      step("reset1");
      RST = 0; ihit = 1;
      step("run");

      idex_dren = 1; idex_rt = 5; ifid_rs = 5;
      step("loaduse");
      idex_rt = 0;
      step("lu_r0");
      idex_rt = 7; ifid_rs = 1; ifid_rt = 7;
      step("loaduse_rt");
      idle(); ihit = 1;

      exmem_dren = 1;
      for (int i = 0; i < 4; i++) step("dwait");
      dhit = 1;
      step("dwait_done");
      idle(); ihit = 1; exmem_dwen = 1; dhit = 1;
      step("dhit_ihit");
      dhit = 0; redirect = 1;
      step("dstall_over_redir");

      idle(); redirect = 1;
      step("rwait0");
      step("rwait1");
      ihit = 1;
      step("redir_hit");
      idle();
      step("fetch_miss");

      idle(); exmem_dren = 1;
      step("pre_rst_dwait");
      RST = 1;
      step("rst_mid_dwait");
      idle(); ihit = 1;
      step("post_rst_dwait");
      idle(); redirect = 1;
      step("pre_rst_rwait");
      RST = 1;
      step("rst_mid_rwait");
      idle(); ihit = 1;
      step("post_rst_rwait");

      // Ten cycles after reset with one load-use stall and one taken redirect.
      idle(); RST = 1;
      step("perf_rst");
      for (int i = 0; i < 10; i++) begin
         idle(); ihit = 1;
         if (i == 2) begin idex_dren = 1; idex_rt = 9; ifid_rt = 9; end
         if (i == 5) redirect = 1;
         step("perf_seq");
      end
`ifdef HAZARD_PERF_EN
      @(negedge CLK);
      check("perf_cyc10", cyc_cnt, 32'd10);
      check("perf_stall1", stall_cnt, 32'd1);
      check("perf_flush1", flush_cnt, 32'd1);
      @(posedge CLK); #1;
      halt_m = halt_m;
      cyc_m++;
`endif

      idle(); ihit = 1; memwb_halt = 1;
      step("halt_enter");
      memwb_halt = 0;
      for (int i = 0; i < 6; i++) begin
         ihit = i[0]; redirect = i[1]; exmem_dren = i[2];
         step("halt_sticky");
      end
      idle(); RST = 1;
      step("halt_rst");
      idle(); ihit = 1;
      step("halt_release");

      for (int i = 0; i < 600; i++) begin
         RST        = ($urandom_range(0, 31) == 0);
         memwb_halt = ($urandom_range(0, 79) == 0);
         ihit       = $urandom_range(0, 3) != 0;
         dhit       = $urandom_range(0, 1) != 0;
         exmem_dren = $urandom_range(0, 3) == 0;
         exmem_dwen = $urandom_range(0, 5) == 0;
         idex_dren  = $urandom_range(0, 1) != 0;
         redirect   = $urandom_range(0, 4) == 0;
         idex_rt    = regbits_t'($urandom_range(0, 3));
         ifid_rs    = regbits_t'($urandom_range(0, 3));
         ifid_rt    = regbits_t'($urandom_range(0, 3));
         step("random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline control unit for the 5-stage core. It generates the enable and flush for every pipeline latch (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC from cache handshakes and hazard inputs. A small FSM tracks data-miss freeze, redirect-waiting-for-fetch and halt. It sits beside the datapath, fed by the latch outputs and the cache hit signals.

## Interface
- CNTW, 32, width of performance counters (only with HAZARD_PERF_EN)
- CLK  in  1  clock, all state updates on posedge
- RST  in  1  synchronous reset, active-high
- ihit  in  1  instruction cache returns the fetch this cycle
- dhit  in  1  data cache completes the MEM-stage access this cycle
- exmem_dren, exmem_dwen  in  1  MEM-stage instruction reads or writes data memory
- idex_dren  in  1  EX-stage instruction is a load
- idex_rt  in  5  load destination register
- ifid_rs, ifid_rt  in  5  ID-stage source registers
- redirect  in  1  taken branch or jump resolved in MEM (from EX/MEM)
- memwb_halt  in  1  halt instruction in WB
- pc_en  out  1  PC load
- ifid_en, idex_en, exmem_en, memwb_en  out  1  latch advance
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1  latch loads bubble (dominates enable)
- halted  out  1  core stopped
- cyc_cnt, stall_cnt, flush_cnt  out  CNTW  perf counters (only with HAZARD_PERF_EN)

## Operation
- Outputs are combinational from state and inputs. State is registered.
- FSM states: RUN, DWAIT, RWAIT, HALT. Reset goes to RUN.
- Conditions:
  - dstall = (exmem_dren|exmem_dwen) & !dhit
  - lu = idex_dren & idex_rt!=0 & (idex_rt==ifid_rs | idex_rt==ifid_rt)
- Priority, highest first:
  1. HALT state, or memwb_halt: every enable and flush is 0 and halted=1. Next state is HALT, sticky until RST.
  2. dstall: every enable is 0 and every flush is 0 (full freeze). Next state is DWAIT.
  3. redirect & !ihit: pc_en, ifid_en, idex_en and exmem_en are 0. memwb_flush=1, so the branch is not duplicated into WB. Next state is RWAIT.
  4. redirect & ihit: pc_en=1, ifid_flush=1, idex_flush=1, exmem_flush=1, memwb_en=1. Next state is RUN.
  5. lu & ihit: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1, memwb_en=1. This inserts one bubble.
  6. ihit: all enables 1. Next state is RUN.
  7. Otherwise (fetch miss): pc_en=0, ifid_flush=1, idex_en=1, exmem_en=1, memwb_en=1. The back end drains while the front end inserts bubbles.
- A DWAIT or RWAIT state re-evaluates its condition each cycle and leaves on the first cycle the condition is false.
- dstall outranks redirect. A branch in MEM never coincides with a memory op in the same instruction, but an exmem memory access with a pending redirect resolves data first.

## Timing
- Zero-cycle latency from inputs to enables and flushes.
- State changes one cycle later.
- Reset values while RST=1:
  - pc_en=0, every latch enable 0, every flush 1 (latches are cleared alongside reset).
  - halted=0, counters 0, state RUN.
- Load-use hazard costs exactly 1 cycle once ihit is present.
- Redirect costs 3 bubbles plus the fetch-miss cycles.
- dhit and ihit in the same cycle: the data access completes and the pipeline advances under rule 6, 5 or 4.
- RST asserted mid-DWAIT or mid-RWAIT returns to RUN on the next edge with no residual stall.

## Configuration
- HAZARD_PERF_EN defined:
  - cyc_cnt increments every non-reset cycle that is not in HALT.
  - stall_cnt increments on cycles where pc_en=0 outside HALT.
  - flush_cnt increments on each rule-4 cycle.
  - All counters saturate at 2^CNTW-1.
- HAZARD_PERF_EN undefined: the counter ports and logic are absent.

## Structure
- hazstate_t, a 2-bit enum (RUN, DWAIT, RWAIT, HALT), goes in cpu_types_pkg next to regbits_t.
- No sub-module. The saturating counter may be a local function or generate loop.

## Test plan
- Reset with RST=1 for 2 cycles -> all flushes 1, pc_en=0, halted=0. After release with ihit=1 -> all enables 1.
- idex_dren=1, idex_rt=5, ifid_rs=5, ihit=1 -> pc_en=0, ifid_en=0, idex_flush=1 for 1 cycle. With idex_rt=0 -> no stall.
- exmem_dren=1, dhit=0 for 4 cycles then 1 -> all enables 0 for 4 cycles with state DWAIT, then advance on the 5th cycle.
- redirect=1, ihit=0 for 2 cycles then 1 -> memwb_flush=1 and pc_en=0 for 2 cycles, then pc_en=1 with ifid/idex/exmem_flush=1 and memwb_en=1.
- memwb_halt=1, then toggle ihit/redirect -> halted=1 and all enables 0 until RST.
- With HAZARD_PERF_EN: 10 cycles containing 1 load-use stall and 1 redirect -> cyc_cnt=10, stall_cnt=1, flush_cnt=1.
